// File: rtl/lr_train_ctrl.sv
// Sequencer for a logistic-regression training datapath.
// It walks the data points in descending order over the requested epochs and fetches features, then strobes predict, error and update.
module lr_train_ctrl #(
  parameter int NUM_FEAT = 4,
  parameter int AW       = 5,
  parameter int EPW      = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic [2:0]     num_dp,
  input  logic [EPW-1:0] num_epochs,
  input  logic           pause,
  input  logic           abort,
  output logic           ram_rd,
  output logic [AW-1:0]  ram_addr,
  output logic           feat_ld,
  output logic [1:0]     feat_idx,
  output logic           pred_en,
  output logic           err_en,
  output logic           upd_en,
  output logic [2:0]     dp_idx,
  output logic [EPW-1:0] epoch_cnt,
  output logic           busy,
  output logic           done
);

  localparam int FCW = $clog2(NUM_FEAT + 1);
  localparam logic [FCW-1:0] FLAST = FCW'(NUM_FEAT);

  typedef enum logic [2:0] {
    IDLE, FETCH, PRED, ERR, UPD, WAIT, DONE
  } state_t;

  state_t         state, state_n;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [2:0]     dp_n, ndp_q, ndp_n;
  logic [EPW-1:0] ep_n, nep_q, nep_n, ep_inc;

  assign ep_inc = epoch_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      fcnt      <= '0;
      dp_idx    <= '0;
      epoch_cnt <= '0;
      ndp_q     <= '0;
      nep_q     <= '0;
    end else begin
      state     <= state_n;
      fcnt      <= fcnt_n;
      dp_idx    <= dp_n;
      epoch_cnt <= ep_n;
      ndp_q     <= ndp_n;
      nep_q     <= nep_n;
    end
  end

  always_comb begin
    state_n  = state;
    fcnt_n   = fcnt;
    dp_n     = dp_idx;
    ep_n     = epoch_cnt;
    ndp_n    = ndp_q;
    nep_n    = nep_q;
    ram_rd   = 1'b0;
    ram_addr = '0;
    feat_ld  = 1'b0;
    feat_idx = '0;
    pred_en  = 1'b0;
    err_en   = 1'b0;
    upd_en   = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          if (num_dp != 3'd0 && num_epochs != '0) begin
            ndp_n   = num_dp;
            nep_n   = num_epochs;
            dp_n    = num_dp - 3'd1;
            ep_n    = '0;
            fcnt_n  = '0;
            state_n = FETCH;
          end else begin
            state_n = DONE;
          end
        end
      end
      FETCH: begin
        // RAM data returns one cycle after the read, so the load lags the address by one
        ram_rd  = (fcnt != FLAST);
        feat_ld = (fcnt != '0);
        if (ram_rd) ram_addr = AW'(NUM_FEAT * int'(dp_idx) + int'(fcnt));
        if (feat_ld) feat_idx = 2'(fcnt - 1'b1);
        if (fcnt == FLAST) begin
          fcnt_n  = '0;
          state_n = PRED;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      PRED: begin
        pred_en = 1'b1;
        state_n = ERR;
      end
      ERR: begin
        err_en  = 1'b1;
        state_n = UPD;
      end
      UPD: begin
        upd_en  = 1'b1;
        state_n = pause ? WAIT : FETCH;
        if (dp_idx != 3'd0) begin
          dp_n = dp_idx - 3'd1;
        end else begin
          ep_n = ep_inc;
          if (ep_inc == nep_q) state_n = DONE;
          else dp_n = ndp_q - 3'd1;
        end
      end
      WAIT: begin
        if (!pause) state_n = FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // abort wins over every other transition and freezes the counters
    if (abort && state != IDLE) begin
      state_n = IDLE;
      fcnt_n  = '0;
      dp_n    = dp_idx;
      ep_n    = epoch_cnt;
    end
  end

endmodule

// File: doc/lr_train_ctrl.md
LR_TRAIN_CTRL -- requirements
Module: lr_train_ctrl

Interface
REQ-001 The block SHALL have the parameter NUM_FEAT, default 4, giving the number of features per data point.
REQ-002 The block SHALL have the parameter AW, default 5, giving the feature-RAM address width.
REQ-003 The block SHALL have the parameter EPW, default 8, giving the epoch counter width.
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  training request; sampled only in IDLE.
REQ-007 num_dp  input  3  number of data points; latched on start accept.
REQ-008 num_epochs  input  EPW  number of passes over the data; latched on start accept.
REQ-009 pause  input  1  hold request; honoured only at data-point boundaries.
REQ-010 abort  input  1  terminate training without a done pulse.
REQ-011 ram_rd  output  1  feature-RAM read strobe; RAM read latency is 1 cycle.
REQ-012 ram_addr  output  AW  feature-RAM address.
REQ-013 feat_ld  output  1  RAM data valid; datapath loads feature register feat_idx.
REQ-014 feat_idx  output  2  feature index for feat_ld.
REQ-015 pred_en  output  1  one-cycle strobe: compute y_cap = sum(feature*wt).
REQ-016 err_en  output  1  one-cycle strobe: compute common_p = (y[dp_idx]-y_cap)>>>7.
REQ-017 upd_en  output  1  one-cycle strobe: apply wt[k] += common_p*feature[k] for all k.
REQ-018 dp_idx  output  3  current data point index.
REQ-019 epoch_cnt  output  EPW  number of completed epochs.
REQ-020 busy  output  1  high whenever the state is not IDLE.
REQ-021 done  output  1  one-cycle completion pulse.

Function
REQ-022 The states SHALL be IDLE, FETCH, PRED, ERR, UPD, WAIT and DONE.
REQ-023 In IDLE, start=1 with num_dp!=0 and num_epochs!=0 SHALL latch both inputs, set dp_idx=num_dp-1 and epoch_cnt=0, and enter FETCH.
REQ-024 In IDLE, start=1 with num_dp==0 or num_epochs==0 SHALL enter DONE directly and issue no datapath strobes.
REQ-025 Data points SHALL be processed in descending order, from num_dp-1 down to 0.
REQ-026 FETCH SHALL last NUM_FEAT+1 cycles.
REQ-027 In FETCH cycle k (k=0..NUM_FEAT-1), ram_rd SHALL be 1 and ram_addr SHALL be NUM_FEAT*dp_idx+k, truncated to AW bits.
REQ-028 In FETCH cycle k+1, feat_ld SHALL be 1 with feat_idx=k.
REQ-029 In the final FETCH cycle, ram_rd SHALL be 0.
REQ-030 PRED, ERR and UPD SHALL each last exactly 1 cycle, asserting pred_en, err_en and upd_en respectively, in that order.
REQ-031 Each data point SHALL take NUM_FEAT+4 cycles (8 at default).
REQ-032 After UPD with dp_idx!=0: dp_idx SHALL decrement.
REQ-033 After UPD with dp_idx==0: epoch_cnt SHALL increment; if the new value equals the latched num_epochs, the next state SHALL be DONE, else dp_idx SHALL reload to num_dp-1.
REQ-034 If pause=1 in the UPD cycle and the next state is not DONE, the FSM SHALL enter WAIT with the counters already advanced.
REQ-035 In WAIT, no strobes SHALL be asserted; the FSM SHALL enter FETCH in the cycle after pause is sampled low.
REQ-036 pause SHALL be ignored in all states except UPD and WAIT.
REQ-037 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no done pulse; counters SHALL hold their last values.
REQ-038 If abort and pause are both high, abort SHALL have priority.
REQ-039 DONE SHALL last 1 cycle with done=1 and busy=1, then return to IDLE.
REQ-040 start while busy SHALL be ignored and SHALL have no effect after the FSM returns to IDLE.
REQ-041 At most one of pred_en, err_en and upd_en SHALL be high in any cycle.

Reset
REQ-042 On RST=1 at a rising edge, the state SHALL be IDLE and every output SHALL be 0 (ram_addr=0, dp_idx=0, epoch_cnt=0, done=0, busy=0).
REQ-043 RST SHALL override start, pause and abort.
REQ-044 RST asserted mid-operation SHALL produce no done pulse.

Verification
REQ-045 num_dp=4, num_epochs=1, start pulse: ram_addr sequence 12-15, 8-11, 4-7, 0-3; 16 ram_rd, 16 feat_ld, 4 each of pred_en/err_en/upd_en; done 33 cycles after the start edge; epoch_cnt=1.
REQ-046 num_dp=2, num_epochs=3: dp_idx sequence 1,0,1,0,1,0; done 49 cycles after start; epoch_cnt=3.
REQ-047 num_epochs=0 (num_dp=4): done high the cycle after start; zero ram_rd and zero strobes.
REQ-048 num_dp=4, num_epochs=1, pause high from point 3 UPD for 5 cycles: WAIT held for 5 cycles with no strobes; FETCH resumes at ram_addr=8; done at cycle 38.
REQ-049 RST during the second FETCH cycle: all outputs 0 next cycle, no done; a new start then reproduces REQ-045 exactly.
REQ-050 start re-pulsed at cycle 10 of the REQ-045 run: no effect; a single done at cycle 33 only.
